// File: rtl/pwm_fade_pkg.sv
// Shared types and the saturating duty-step helper for the PWM fade sequencer.
// Pure definitions: no latency, no flow control.
package pwm_fade_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int DUTY_RESET = 0;

    // Differences are taken one bit wider than the operands, so the step never
    // wraps and the result never passes the target.
    function automatic logic [31:0] sat_step(input logic [31:0] duty,
                                             input logic [31:0] target,
                                             input logic [31:0] step);
        logic [32:0] diff;
        logic [31:0] result;
        result = duty;
        if (target > duty) begin
            diff   = {1'b0, target} - {1'b0, duty};
            result = (diff <= {1'b0, step}) ? target : duty + step;
        end else if (target < duty) begin
            diff   = {1'b0, duty} - {1'b0, target};
            result = (diff <= {1'b0, step}) ? target : duty - step;
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_fade_step.sv
// Next-duty calculator: moves duty one step toward target, clamping at target.
// Purely combinational, zero latency; no flow control.
module pwm_fade_step
    import pwm_fade_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] next_duty
);

    logic [31:0] res;

    assign res       = sat_step(32'(duty), 32'(target), 32'(step));
    assign next_duty = res[WIDTH-1:0];

    if (WIDTH < 32) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^res[31:WIDTH];
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Fade controller for pwm_module: ramps duty one step per PWM period, dwells, then finishes or bounces.
// Command lands one cycle after handshake; duty moves only on period_tick; cfg_ready is high only when idle.
module pwm_fade_sequencer
    import pwm_fade_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WIDTH-1:0]  cfg_start,
    input  logic [WIDTH-1:0]  cfg_end,
    input  logic [WIDTH-1:0]  cfg_step,
    input  logic [HOLD_W-1:0] cfg_hold,
    input  logic [WIDTH-1:0]  cfg_max,
    input  logic              cfg_pingpong,
    input  logic              period_tick,
    input  logic              abort,
    output logic [WIDTH-1:0]  duty,
    output logic [WIDTH-1:0]  max_value,
    output logic              busy,
    output logic              done
);

    state_t              state;
    logic [WIDTH-1:0]    target;
    logic [WIDTH-1:0]    start_c;
    logic [WIDTH-1:0]    end_c;
    logic [WIDTH-1:0]    step_c;
    logic [HOLD_W-1:0]   hold_cfg;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                pingpong;
    logic [WIDTH-1:0]    next_duty;
    logic [WIDTH-1:0]    start_clamp;
    logic [WIDTH-1:0]    end_clamp;

    // Clamp to max_value up front so duty can never exceed the period.
    assign start_clamp = (cfg_start > cfg_max) ? cfg_max : cfg_start;
    assign end_clamp   = (cfg_end   > cfg_max) ? cfg_max : cfg_end;

    assign busy      = (state != ST_IDLE);
    assign cfg_ready = (state == ST_IDLE);

    pwm_fade_step #(.WIDTH(WIDTH)) u_step (
        .duty      (duty),
        .target    (target),
        .step      (step_c),
        .next_duty (next_duty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            duty      <= WIDTH'(DUTY_RESET);
            max_value <= '1;
            done      <= 1'b0;
            target    <= '0;
            start_c   <= '0;
            end_c     <= '0;
            step_c    <= '0;
            hold_cfg  <= '0;
            hold_cnt  <= '0;
            pingpong  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                duty  <= WIDTH'(DUTY_RESET);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cfg_valid) begin
                            start_c   <= start_clamp;
                            end_c     <= end_clamp;
                            step_c    <= (cfg_step == '0) ? WIDTH'(1) : cfg_step;
                            hold_cfg  <= cfg_hold;
                            pingpong  <= cfg_pingpong;
                            duty      <= start_clamp;
                            max_value <= cfg_max;
                            target    <= end_clamp;
                            state     <= ST_RAMP;
                        end
                    end
                    ST_RAMP: begin
                        if (period_tick) begin
                            duty <= next_duty;
                            if (next_duty == target) begin
                                hold_cnt <= hold_cfg;
                                state    <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (period_tick) begin
                            if (hold_cnt != '0) begin
                                hold_cnt <= hold_cnt - 1'b1;
                            end else if (pingpong) begin
                                target <= (target == end_c) ? start_c : end_c;
                                state  <= ST_RAMP;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench for pwm_fade_sequencer: directed and random fade commands against a tick-sequence model.
module tb_pwm_fade_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_start;
    logic [7:0]  cfg_end;
    logic [7:0]  cfg_step;
    logic [15:0] cfg_hold;
    logic [7:0]  cfg_max;
    logic        cfg_pingpong;
    logic        period_tick;
    logic        abort;
    logic [7:0]  duty;
    logic [7:0]  max_value;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    pwm_fade_sequencer #(.WIDTH(8), .HOLD_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_start    (cfg_start),
        .cfg_end      (cfg_end),
        .cfg_step     (cfg_step),
        .cfg_hold     (cfg_hold),
        .cfg_max      (cfg_max),
        .cfg_pingpong (cfg_pingpong),
        .period_tick  (period_tick),
        .abort        (abort),
        .duty         (duty),
        .max_value    (max_value),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected duty after every tick of one leg: walk toward 'to' one step at a
    // time, then sit at 'to' for h+1 ticks (the last being the exit tick).
    function automatic void add_leg(int from, int to, int st, int h);
        int v;
        v = from;
        if (from == to) exp_q.push_back(to);
        while (v != to) begin
            if (to > v) v = (v + st > to) ? to : v + st;
            else        v = (v - st < to) ? to : v - st;
            exp_q.push_back(v);
        end
        for (int k = 0; k <= h; k++) exp_q.push_back(to);
    endfunction

    task automatic send_cfg(input int s, input int e, input int st, input int h,
                            input int mx, input bit pp);
        cfg_start    = 8'(s);
        cfg_end      = 8'(e);
        cfg_step     = 8'(st);
        cfg_hold     = 16'(h);
        cfg_max      = 8'(mx);
        cfg_pingpong = pp;
        cfg_valid    = 1'b1;
        cycle();
        cfg_valid    = 1'b0;
    endtask

    task automatic tick_once();
        repeat ($urandom_range(0, 2)) cycle();
        period_tick = 1'b1;
        cycle();
        period_tick = 1'b0;
    endtask

    task automatic run_cmd(input int s, input int e, input int st, input int h,
                           input int mx, input bit pp, input int n_pp, input string tag);
        int sc, ec, stc, n, a, b, t;
        sc  = (s > mx) ? mx : s;
        ec  = (e > mx) ? mx : e;
        stc = (st == 0) ? 1 : st;
        exp_q.delete();
        if (!pp) begin
            add_leg(sc, ec, stc, h);
        end else begin
            a = sc;
            b = ec;
            while (exp_q.size() < n_pp) begin
                add_leg(a, b, stc, h);
                t = a; a = b; b = t;
            end
        end
        send_cfg(s, e, st, h, mx, pp);
        n_checks++;
        if (int'(duty) !== sc || int'(max_value) !== mx || busy !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: duty=%0d max=%0d busy=%b rdy=%b, need duty=%0d max=%0d busy=1 rdy=0",
                     tag, duty, max_value, busy, cfg_ready, sc, mx);
        end
        n = pp ? n_pp : exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick_once();
            n_checks++;
            if (int'(duty) !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s tick%0d duty: got %0d, need %0d", tag, i + 1, duty, exp_q[i]);
            end
            n_checks++;
            if (done !== (!pp && i == n - 1)) begin
                n_fail++;
                $display("FAIL %s tick%0d done: got %b, need %b", tag, i + 1, done, (!pp && i == n - 1));
            end
            n_checks++;
            if (busy === 1'b1 && duty > max_value) begin
                n_fail++;
                $display("FAIL %s tick%0d duty above max: duty=%0d max=%0d", tag, i + 1, duty, max_value);
            end
        end
        if (!pp) begin
            cycle();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || int'(duty) !== ec) begin
                n_fail++;
                $display("FAIL %s after done: done=%b busy=%b rdy=%b duty=%0d, need 0 0 1 %0d",
                         tag, done, busy, cfg_ready, duty, ec);
            end
        end
    endtask

    task automatic do_abort(input string tag, input int mx);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        n_checks++;
        if (duty !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1 || int'(max_value) !== mx) begin
            n_fail++;
            $display("FAIL %s abort: duty=%0d busy=%b done=%b rdy=%b max=%0d, need 0 0 0 1 %0d",
                     tag, duty, busy, done, cfg_ready, max_value, mx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (duty !== 8'd0 || max_value !== 8'hff || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: duty=%0d max=%0d busy=%b done=%b rdy=%b, need 0 255 0 0 1",
                     duty, max_value, busy, done, cfg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        period_tick = 1'b1;
        cycle();
        period_tick = 1'b0;
        n_checks++;
        if (duty !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_tick: duty=%0d busy=%b done=%b, need 0 0 0", duty, busy, done);
        end
    endtask

    task automatic test_directed();
        run_cmd(10, 50, 15, 0, 255, 1'b0, 0, "up_ramp");
        run_cmd(200, 3, 100, 2, 150, 1'b0, 0, "down_clamp");
        run_cmd(7, 7, 0, 2, 255, 1'b0, 0, "equal_step0");
        run_cmd(0, 3, 0, 0, 255, 1'b0, 0, "step0_ramp");
        run_cmd(0, 255, 255, 1, 255, 1'b0, 0, "full_step");
    endtask

    task automatic test_pingpong();
        run_cmd(0, 4, 2, 1, 255, 1'b1, 20, "pingpong");
        do_abort("pingpong", 255);
        run_cmd(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 90)),
                int'($urandom_range(0, 2)), 200, 1'b1, 24, "pingpong_rand");
        do_abort("pingpong_rand", 200);
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            run_cmd(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 80)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 255)), 1'b0, 0, "random");
        end
    endtask

    task automatic test_abort();
        send_cfg(0, 200, 10, 0, 250, 1'b0);
        tick_once();
        tick_once();
        n_checks++;
        if (duty !== 8'd20) begin
            n_fail++;
            $display("FAIL abort_pre: duty got %0d, need 20", duty);
        end
        period_tick = 1'b1;
        do_abort("abort_tick", 250);
        period_tick = 1'b0;
        cfg_start = 8'd9; cfg_end = 8'd90; cfg_step = 8'd3; cfg_max = 8'd100;
        cfg_valid = 1'b1;
        abort     = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        abort     = 1'b0;
        cycle();
        n_checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || duty !== 8'd0 || max_value !== 8'd250) begin
            n_fail++;
            $display("FAIL abort_cfg: busy=%b rdy=%b duty=%0d max=%0d, need 0 1 0 250",
                     busy, cfg_ready, duty, max_value);
        end
    endtask

    task automatic test_ignored_cfg();
        exp_q.delete();
        add_leg(0, 30, 10, 1);
        send_cfg(0, 30, 10, 1, 255, 1'b0);
        tick_once();
        cfg_start = 8'd99; cfg_end = 8'd5; cfg_step = 8'd50; cfg_max = 8'd50; cfg_hold = 16'd9;
        cfg_valid = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        n_checks++;
        if (duty !== 8'd10 || max_value !== 8'd255 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_cfg: duty=%0d max=%0d busy=%b, need 10 255 1", duty, max_value, busy);
        end
        for (int i = 1; i < exp_q.size(); i++) begin
            tick_once();
            n_checks++;
            if (int'(duty) !== exp_q[i] || done !== (i == exp_q.size() - 1)) begin
                n_fail++;
                $display("FAIL ignored_cfg tick%0d: duty=%0d done=%b, need %0d %b",
                         i + 1, duty, done, exp_q[i], (i == exp_q.size() - 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        send_cfg(5, 6, 1, 0, 255, 1'b0);
        tick_once();
        tick_once();
        n_checks++;
        if (done !== 1'b1 || cfg_ready !== 1'b1 || duty !== 8'd6) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b rdy=%b duty=%0d, need 1 1 6", done, cfg_ready, duty);
        end
        send_cfg(40, 20, 5, 0, 100, 1'b0);
        n_checks++;
        if (done !== 1'b0 || duty !== 8'd40 || max_value !== 8'd100 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: done=%b duty=%0d max=%0d busy=%b, need 0 40 100 1",
                     done, duty, max_value, busy);
        end
        do_abort("b2b", 100);
    endtask

    task automatic test_reset_mid();
        send_cfg(10, 10, 1, 5, 120, 1'b0);
        tick_once();
        tick_once();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (duty !== 8'd0 || max_value !== 8'hff || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: duty=%0d max=%0d busy=%b done=%b rdy=%b, need 0 255 0 0 1",
                     duty, max_value, busy, done, cfg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        period_tick = 1'b1;
        cycle();
        period_tick = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || duty !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_after: busy=%b done=%b duty=%0d, need 0 0 0", busy, done, duty);
        end
    endtask

    initial begin
        cfg_valid    = 1'b0;
        cfg_start    = '0;
        cfg_end      = '0;
        cfg_step     = '0;
        cfg_hold     = '0;
        cfg_max      = '0;
        cfg_pingpong = 1'b0;
        period_tick  = 1'b0;
        abort        = 1'b0;
        test_reset();
        test_directed();
        test_pingpong();
        test_random();
        test_abort();
        test_ignored_cfg();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
